// File: rtl/apple_pkg.sv
// Shared playfield geometry, LFSR seed and state type for the apple placer.
package apple_pkg;

   localparam int          GAME_WIDTH  = 30;
   localparam int          GAME_HEIGHT = 14;
   localparam logic [15:0] LFSR_SEED   = 16'hACE1;

   typedef enum logic [1:0] {
      DRAW,
      WAIT_FIRST,
      SCAN,
      PLACED
   } apple_state_t;

   // Coordinates are 1-based; 0 and anything past the edge are off the board.
   function automatic logic on_board(logic [4:0] x, logic [3:0] y);
      return (x != 5'd0) && (int'(x) <= GAME_WIDTH) &&
             (y != 4'd0) && (int'(y) <= GAME_HEIGHT);
   endfunction

endpackage

// File: rtl/apple_if.sv
// Snake-segment stream into the apple placer and the apple/eat signals back out.
interface apple_if;

   logic [4:0] i_pos_x;
   logic [3:0] i_pos_y;
   logic       i_pos_first;
   logic       i_pos_last;
   logic       i_pos_valid;
   logic [4:0] o_apple_x;
   logic [3:0] o_apple_y;
   logic       o_apple_valid;
   logic       o_eat;

   modport master (
      output i_pos_x, i_pos_y, i_pos_first, i_pos_last, i_pos_valid,
      input  o_apple_x, o_apple_y, o_apple_valid, o_eat
   );

   modport slave (
      input  i_pos_x, i_pos_y, i_pos_first, i_pos_last, i_pos_valid,
      output o_apple_x, o_apple_y, o_apple_valid, o_eat
   );

endinterface

// File: rtl/apple_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16/14/13/11; never reaches zero from a non-zero seed.
module lfsr16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   output logic [15:0] out
);

   always_ff @(posedge clk) begin
      if (rst) out <= seed;
      else     out <= {out[14:0], out[15] ^ out[13] ^ out[12] ^ out[10]};
   end

endmodule

// File: rtl/apple.sv
// Draws a random apple position, verifies it against a full snake frame, then waits to be eaten.
//
// state      | meaning
// DRAW       | try lfsr candidate each cycle until it lies on the board
// WAIT_FIRST | candidate latched, waiting for the head of a frame
// SCAN       | comparing frame entries against the candidate
// PLACED     | apple valid, watching the head for an eat
module apple
   import apple_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   apple_if.slave bus
);

   logic [15:0]  lfsr;
   apple_state_t state;
   logic [4:0]   cand_x;
   logic [3:0]   cand_y;
   logic         hit;
   logic         pos_match;
   logic         apple_match;
   logic         scan_hit;

   lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (LFSR_SEED),
      .out  (lfsr)
   );

   always_comb begin
      pos_match   = (bus.i_pos_x == cand_x) && (bus.i_pos_y == cand_y);
      apple_match = (bus.i_pos_x == bus.o_apple_x) && (bus.i_pos_y == bus.o_apple_y);
      // A head entry starts a fresh frame, so any earlier hit is discarded.
      scan_hit    = pos_match || (hit && !bus.i_pos_first);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= DRAW;
         cand_x            <= '0;
         cand_y            <= '0;
         hit               <= 1'b0;
         bus.o_apple_x     <= '0;
         bus.o_apple_y     <= '0;
         bus.o_apple_valid <= 1'b0;
         bus.o_eat         <= 1'b0;
      end else begin
         bus.o_eat <= 1'b0;
         case (state)
            DRAW: begin
               if (on_board(lfsr[4:0], lfsr[12:9])) begin
                  cand_x <= lfsr[4:0];
                  cand_y <= lfsr[12:9];
                  state  <= WAIT_FIRST;
               end
            end
            WAIT_FIRST, SCAN: begin
               if (bus.i_pos_valid && (bus.i_pos_first || state == SCAN)) begin
                  hit <= scan_hit;
                  if (bus.i_pos_last) begin
                     if (scan_hit) begin
                        state <= DRAW;
                     end else begin
                        bus.o_apple_x     <= cand_x;
                        bus.o_apple_y     <= cand_y;
                        bus.o_apple_valid <= 1'b1;
                        state             <= PLACED;
                     end
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            PLACED: begin
               if (bus.i_pos_valid && bus.i_pos_first && apple_match) begin
                  bus.o_eat         <= 1'b1;
                  bus.o_apple_valid <= 1'b0;
                  state             <= DRAW;
               end
            end
            default: state <= DRAW;
         endcase
      end
   end

endmodule

// File: tb/tb_apple.sv
// Randomized frames against a transaction-level model of the apple placer.
module tb_apple;
   import apple_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   apple_if bus ();

   apple dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_lfsr;       // lfsr value the DUT will use at the next edge
   int          cx, cy;
   bit          placed;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic bit in_field(input int x, input int y);
      return x >= 1 && x <= GAME_WIDTH && y >= 1 && y <= GAME_HEIGHT;
   endfunction

   task automatic drive(input bit v, input bit f, input bit l, input int x, input int y);
      bus.i_pos_valid = v;
      bus.i_pos_first = f;
      bus.i_pos_last  = l;
      bus.i_pos_x     = 5'(x);
      bus.i_pos_y     = 4'(y);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) m_lfsr = LFSR_SEED;
      else     m_lfsr = lfsr_next(m_lfsr);
      #1;
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b1;
      idle();
      for (int i = 0; i < n; i++) begin
         tick();
         check("rst_eat", int'(bus.o_eat), 0);
         check("rst_valid", int'(bus.o_apple_valid), 0);
      end
      rst = 1'b0;
   endtask

   // Steps through draw cycles until the model accepts a candidate.
   task automatic do_draw(output int ox, output int oy);
      int x, y;
      bit ok;
      ox = 0;
      oy = 0;
      idle();
      for (int n = 0; n < 200; n++) begin
         x  = int'(m_lfsr[4:0]);
         y  = int'(m_lfsr[12:9]);
         ok = in_field(x, y);
         tick();
         check("draw_eat", int'(bus.o_eat), 0);
         check("draw_valid", int'(bus.o_apple_valid), 0);
         if (ok) begin
            ox = x;
            oy = y;
            return;
         end
      end
   endtask

   task automatic scan_frame(input int ax, input int ay, output bit ok);
      int len, x, y;
      bit hit;
      if ($urandom_range(0, 2) == 0) begin
         drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), ax, ay);
         tick();
      end
      if ($urandom_range(0, 2) == 0) begin
         len = $urandom_range(1, 3);
         for (int i = 0; i < len; i++) begin
            drive(1'b1, i == 0, 1'b0, ax, ay);
            tick();
         end
      end
      hit = 1'b0;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
         x = $urandom_range(1, GAME_WIDTH);
         y = $urandom_range(1, GAME_HEIGHT);
         if ($urandom_range(0, 4) == 0) begin
            x = ax;
            y = ay;
         end
         if (x == ax && y == ay) hit = 1'b1;
         drive(1'b1, i == 0, i == len - 1, x, y);
         tick();
         if (i < len - 1) begin
            check("scan_valid", int'(bus.o_apple_valid), 0);
            if ($urandom_range(0, 2) == 0) begin
               drive(1'b0, 1'b1, 1'b1, ax, ay);
               tick();
            end
         end
      end
      ok = !hit;
      check("place_valid", int'(bus.o_apple_valid), int'(ok));
      if (ok) begin
         check("place_x", int'(bus.o_apple_x), ax);
         check("place_y", int'(bus.o_apple_y), ay);
      end
      idle();
   endtask

   task automatic placed_phase(input int ax, input int ay);
      int nf, len, x, y;
      nf = $urandom_range(0, 2);
      for (int f = 0; f < nf; f++) begin
         len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) begin
            x = $urandom_range(1, GAME_WIDTH);
            y = $urandom_range(1, GAME_HEIGHT);
            if (i == 0) begin
               while (x == ax && y == ay) x = $urandom_range(1, GAME_WIDTH);
            end else if ($urandom_range(0, 1) == 0) begin
               x = ax;
               y = ay;
            end
            drive(1'b1, i == 0, i == len - 1, x, y);
            tick();
            check("body_eat", int'(bus.o_eat), 0);
            check("body_valid", int'(bus.o_apple_valid), 1);
         end
         drive(1'b0, 1'b1, 1'b0, ax, ay);
         tick();
         check("idle_eat", int'(bus.o_eat), 0);
      end
      drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), ax, ay);
      tick();
      check("eat_pulse", int'(bus.o_eat), 1);
      check("eat_valid", int'(bus.o_apple_valid), 0);
      check("eat_hold_x", int'(bus.o_apple_x), ax);
      idle();
   endtask

   // From reset the seed 16'hACE1 yields candidate (1,6); place it beside a segment at (20,10).
   task automatic first_place();
      do_draw(cx, cy);
      drive(1'b1, 1'b1, 1'b1, 20, 10);
      tick();
      check("seed_valid", int'(bus.o_apple_valid), 1);
      check("seed_x", int'(bus.o_apple_x), 1);
      check("seed_y", int'(bus.o_apple_y), 6);
      idle();
   endtask

   initial begin
      rst    = 1'b1;
      m_lfsr = '0;
      idle();
      apply_reset(3);
      check("rst_x", int'(bus.o_apple_x), 0);
      check("rst_y", int'(bus.o_apple_y), 0);

      first_place();

      // Body segment on the apple must not eat.
      drive(1'b1, 1'b1, 1'b0, 20, 10);
      tick();
      drive(1'b1, 1'b0, 1'b1, 1, 6);
      tick();
      check("body_no_eat", int'(bus.o_eat), 0);
      check("body_keep", int'(bus.o_apple_valid), 1);

      drive(1'b1, 1'b1, 1'b0, 1, 6);
      tick();
      check("head_eat", int'(bus.o_eat), 1);
      check("head_drop", int'(bus.o_apple_valid), 0);

      // Single segment sitting on the candidate rejects it.
      do_draw(cx, cy);
      drive(1'b1, 1'b1, 1'b1, cx, cy);
      tick();
      check("self_hit", int'(bus.o_apple_valid), 0);
      idle();

      for (int r = 0; r < 40; r++) begin
         do_draw(cx, cy);
         scan_frame(cx, cy, placed);
         if (placed) placed_phase(cx, cy);
      end

      // Reset in the middle of a scan.
      do_draw(cx, cy);
      drive(1'b1, 1'b1, 1'b0, 20, 10);
      tick();
      apply_reset(2);
      first_place();

      // Reset on the very edge that would have eaten.
      drive(1'b1, 1'b1, 1'b0, 1, 6);
      rst = 1'b1;
      tick();
      check("rst_eat_edge", int'(bus.o_eat), 0);
      check("rst_eat_valid", int'(bus.o_apple_valid), 0);
      apply_reset(1);
      first_place();

      // Reset during the eat pulse itself.
      drive(1'b1, 1'b1, 1'b0, 1, 6);
      tick();
      check("pre_rst_eat", int'(bus.o_eat), 1);
      apply_reset(1);
      first_place();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
